// File: rtl/locker_pkg.sv
// Shared types and defaults for the locker keypad sequencing controller.
package locker_pkg;

  localparam int DEF_DIGIT_W  = 4;
  localparam int DEF_CODE_LEN = 4;
  localparam logic [DEF_CODE_LEN*DEF_DIGIT_W-1:0] DEF_RESET_CODE = 16'h1234;

  typedef enum logic [2:0] {
    LOCKED,
    CHECK,
    OPEN,
    SET_ENTRY,
    LOCKOUT
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/locker_digit_eq.sv
// Single keypad-digit equality compare, time-multiplexed across the code by the caller.
module locker_digit_eq
  import locker_pkg::*;
#(
  parameter int DIGIT_W = DEF_DIGIT_W
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               eq
);

  assign eq = (a == b);

endmodule

// File: rtl/locker_seq_ctrl.sv
// Locker keypad sequencer: entry buffering, digit-serial code check, unlock/relock,
// failed-attempt lockout and code change.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// LOCKED    | closed, collecting digits for an unlock attempt
// CHECK     | comparing one digit per cycle, then one verdict cycle
// OPEN      | lock open, relock timer running
// SET_ENTRY | lock open, collecting a new code, relock timer frozen
// LOCKOUT   | too many wrong attempts, all inputs ignored until timeout
module locker_seq_ctrl
  import locker_pkg::*;
#(
  parameter int DIGIT_W     = DEF_DIGIT_W,
  parameter int CODE_LEN    = DEF_CODE_LEN,
  parameter int MAX_TRIES   = 3,
  parameter int UNLOCK_CYC  = 500,
  parameter int LOCKOUT_CYC = 1000,
  parameter logic [CODE_LEN*DIGIT_W-1:0] RESET_CODE = DEF_RESET_CODE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           key_valid,
  input  logic [DIGIT_W-1:0]             key_digit,
  input  logic                           key_enter,
  input  logic                           set_mode,
  input  logic                           lock_cmd,
  output logic                           unlocked,
  output logic                           lockout,
  output logic                           alarm,
  output logic                           code_err,
  output logic                           busy,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left
);

  localparam int CNT_W = $clog2(CODE_LEN + 1);
  localparam int TMR_W = $clog2(max_int(UNLOCK_CYC, LOCKOUT_CYC) + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  localparam logic [CNT_W-1:0] FULL      = CNT_W'(CODE_LEN);
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(CODE_LEN - 1);
  localparam logic [TMR_W-1:0] T_UNLOCK  = TMR_W'(UNLOCK_CYC);
  localparam logic [TMR_W-1:0] T_LOCKOUT = TMR_W'(LOCKOUT_CYC);
  localparam logic [TMR_W-1:0] T_ONE     = TMR_W'(1);
  localparam logic [TRY_W-1:0] TRIES_MAX = TRY_W'(MAX_TRIES);
  localparam logic [TRY_W-1:0] TRIES_ONE = TRY_W'(1);

  state_e                           state;
  logic [CODE_LEN-1:0][DIGIT_W-1:0] entry;
  logic [CODE_LEN-1:0][DIGIT_W-1:0] code;
  logic [CNT_W-1:0]                 count;
  logic [CNT_W-1:0]                 index;
  logic                             mismatch;
  logic [TMR_W-1:0]                 timer;

  logic [DIGIT_W-1:0] entry_digit;
  logic [DIGIT_W-1:0] code_digit;
  logic               digit_eq;
  logic               entry_full;
  logic               accept_digit;

  assign entry_full   = (count == FULL);
  assign accept_digit = key_valid && !key_enter && !entry_full &&
                        (state == LOCKED || state == SET_ENTRY);

  // index 0 is the first digit typed, which lives in the top slot
  always_comb begin
    entry_digit = '0;
    code_digit  = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (index == CNT_W'(i)) begin
        entry_digit = entry[CODE_LEN-1-i];
        code_digit  = code[CODE_LEN-1-i];
      end
    end
  end

  locker_digit_eq #(
    .DIGIT_W(DIGIT_W)
  ) u_digit_eq (
    .a (entry_digit),
    .b (code_digit),
    .eq(digit_eq)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOCKED;
      unlocked   <= 1'b0;
      lockout    <= 1'b0;
      alarm      <= 1'b0;
      code_err   <= 1'b0;
      busy       <= 1'b0;
      tries_left <= TRIES_MAX;
      code       <= RESET_CODE;
      entry      <= '0;
      count      <= '0;
      index      <= '0;
      mismatch   <= 1'b0;
      timer      <= '0;
    end else begin
      alarm    <= 1'b0;
      code_err <= 1'b0;

      if (accept_digit) begin
        entry <= {entry[CODE_LEN-2:0], key_digit};
        count <= count + 1'b1;
      end

      case (state)
        LOCKED: begin
          // a short entry skips the compare and lands directly on the verdict cycle
          if (key_enter) begin
            state    <= CHECK;
            mismatch <= !entry_full;
            busy     <= entry_full;
            index    <= entry_full ? '0 : FULL;
          end
        end

        CHECK: begin
          if (index != FULL) begin
            mismatch <= mismatch | !digit_eq;
            index    <= index + 1'b1;
            if (index == LAST) busy <= 1'b0;
          end else begin
            entry <= '0;
            count <= '0;
            index <= '0;
            if (!mismatch) begin
              state      <= OPEN;
              unlocked   <= 1'b1;
              tries_left <= TRIES_MAX;
              timer      <= T_UNLOCK;
            end else if (tries_left > TRIES_ONE) begin
              state      <= LOCKED;
              tries_left <= tries_left - 1'b1;
            end else begin
              state      <= LOCKOUT;
              tries_left <= '0;
              lockout    <= 1'b1;
              alarm      <= 1'b1;
              timer      <= T_LOCKOUT;
            end
          end
        end

        OPEN: begin
          if (lock_cmd || timer <= T_ONE) begin
            state    <= LOCKED;
            unlocked <= 1'b0;
            timer    <= '0;
          end else if (set_mode) begin
            state <= SET_ENTRY;
            entry <= '0;
            count <= '0;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        SET_ENTRY: begin
          if (lock_cmd) begin
            state    <= LOCKED;
            unlocked <= 1'b0;
            timer    <= '0;
            entry    <= '0;
            count    <= '0;
          end else if (key_enter) begin
            if (entry_full) code <= entry;
            else            code_err <= 1'b1;
            state <= OPEN;
            timer <= T_UNLOCK;
            entry <= '0;
            count <= '0;
          end
        end

        LOCKOUT: begin
          if (timer <= T_ONE) begin
            state      <= LOCKED;
            lockout    <= 1'b0;
            tries_left <= TRIES_MAX;
            timer      <= '0;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        default: state <= LOCKED;
      endcase
    end
  end

endmodule

// File: tb/tb_locker_seq_ctrl.sv
// Bench for locker_seq_ctrl: fixed vector table, directed corner sequences and
// randomized traffic, all cross-checked against an attempt-level reference model.
module tb_locker_seq_ctrl;

  localparam int UNL  = 8;
  localparam int LCK  = 16;
  localparam int MAXT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'h0;
  logic       key_enter = 1'b0;
  logic       set_mode = 1'b0;
  logic       lock_cmd = 1'b0;
  logic       unlocked, lockout, alarm, code_err, busy;
  logic [1:0] tries_left;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  locker_seq_ctrl #(
    .UNLOCK_CYC (UNL),
    .LOCKOUT_CYC(LCK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_digit (key_digit),
    .key_enter (key_enter),
    .set_mode  (set_mode),
    .lock_cmd  (lock_cmd),
    .unlocked  (unlocked),
    .lockout   (lockout),
    .alarm     (alarm),
    .code_err  (code_err),
    .busy      (busy),
    .tries_left(tries_left)
  );

  // Reference model: tracks attempts as whole transactions with remaining-cycle counts.
  int         m_open, m_lock, m_pend, m_tries;
  bit         m_setting, m_ok, m_full, m_alarm, m_cerr;
  logic [15:0] m_code;
  int         dq[$];

  function automatic logic [15:0] entered_value();
    logic [15:0] v = 16'h0;
    foreach (dq[i]) v = (v << 4) | 16'(dq[i]);
    return v;
  endfunction

  task automatic model_step(input bit r, input bit kv, input logic [3:0] kd,
                            input bit ke, input bit sm, input bit lc);
    m_alarm = 1'b0;
    m_cerr  = 1'b0;
    if (r) begin
      m_open = 0; m_lock = 0; m_pend = 0; m_tries = MAXT;
      m_setting = 1'b0; m_full = 1'b0; m_code = 16'h1234;
      dq.delete();
    end else if (m_pend > 0) begin
      m_pend--;
      if (m_pend == 0) begin
        dq.delete();
        if (m_ok) begin
          m_open  = UNL;
          m_tries = MAXT;
        end else if (m_tries > 1) begin
          m_tries--;
        end else begin
          m_tries = 0;
          m_lock  = LCK;
          m_alarm = 1'b1;
        end
      end
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_tries = MAXT;
    end else if (m_setting) begin
      if (lc) begin
        m_setting = 1'b0; m_open = 0; dq.delete();
      end else if (ke) begin
        if (dq.size() == 4) m_code = entered_value();
        else                m_cerr = 1'b1;
        m_setting = 1'b0; m_open = UNL; dq.delete();
      end else if (kv && dq.size() < 4) begin
        dq.push_back(int'(kd));
      end
    end else if (m_open > 0) begin
      if (lc)                     m_open = 0;
      else if (sm && m_open > 1) begin
        m_setting = 1'b1; dq.delete();
      end else                    m_open--;
    end else begin
      if (ke) begin
        m_full = (dq.size() == 4);
        m_ok   = m_full && (entered_value() == m_code);
        m_pend = m_full ? 5 : 1;
      end else if (kv && dq.size() < 4) begin
        dq.push_back(int'(kd));
      end
    end
  endtask

  function automatic logic [6:0] model_out();
    return {(m_setting || m_open > 0), (m_lock > 0), m_alarm, m_cerr,
            (m_full && m_pend > 1), 2'(m_tries)};
  endfunction

  function automatic logic [6:0] dut_out();
    return {unlocked, lockout, alarm, code_err, busy, tries_left};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit kv, input logic [3:0] kd,
                     input bit ke, input bit sm, input bit lc);
    @(negedge clk);
    rst = r; key_valid = kv; key_digit = kd; key_enter = ke;
    set_mode = sm; lock_cmd = lc;
    @(posedge clk);
    model_step(r, kv, kd, ke, sm, lc);
    #1;
    chk("model {unl,lko,alm,cerr,busy,tries}", 32'(dut_out()), 32'(model_out()));
  endtask

  task automatic key(input logic [3:0] d);  cyc(0, 1, d, 0, 0, 0); endtask
  task automatic enter();                    cyc(0, 0, 0, 1, 0, 0); endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask
  task automatic code_entry(input logic [15:0] c);
    for (int k = 3; k >= 0; k--) key(c[k*4 +: 4]);
    enter();
  endtask

  // Vector table: inputs plus hand-derived outputs after the edge.
  typedef struct {
    bit         r, kv;
    logic [3:0] kd;
    bit         ke, sm, lc;
    logic [6:0] exp;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [6:0] o(bit u, bit lo, bit al, bit ce, bit bs, logic [1:0] tr);
    return {u, lo, al, ce, bs, tr};
  endfunction

  function automatic void add(bit r, bit kv, logic [3:0] kd, bit ke, bit sm, bit lc,
                              logic [6:0] exp);
    vec_t v;
    v.r = r; v.kv = kv; v.kd = kd; v.ke = ke; v.sm = sm; v.lc = lc; v.exp = exp;
    vecs.push_back(v);
  endfunction

  function automatic void add_attempt(logic [15:0] c, logic [1:0] tr, logic [6:0] verdict);
    for (int k = 3; k >= 0; k--) add(0, 1, c[k*4 +: 4], 0, 0, 0, o(0, 0, 0, 0, 0, tr));
    add(0, 0, 0, 1, 0, 0, o(0, 0, 0, 0, 1, tr));
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 1, tr));
    add(0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, tr));
    add(0, 0, 0, 0, 0, 0, verdict);
  endfunction

  initial begin
    int r;
    int n;

    add(1, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 3));
    add_attempt(16'h1234, 2'd3, o(1, 0, 0, 0, 0, 3));
    for (int i = 0; i < UNL - 1; i++) add(0, 0, 0, 0, 0, 0, o(1, 0, 0, 0, 0, 3));
    add(0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 3));
    add_attempt(16'h1235, 2'd3, o(0, 0, 0, 0, 0, 2));
    add_attempt(16'h1235, 2'd2, o(0, 0, 0, 0, 0, 1));
    add_attempt(16'h1235, 2'd1, o(0, 1, 1, 0, 0, 0));
    for (int k = 1; k <= 4; k++) add(0, 1, 4'(k), 0, 0, 0, o(0, 1, 0, 0, 0, 0));
    add(0, 0, 0, 1, 0, 0, o(0, 1, 0, 0, 0, 0));
    for (int i = 0; i < LCK - 6; i++) add(0, 0, 0, 0, 0, 0, o(0, 1, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 3));
    add(0, 0, 0, 1, 0, 0, o(0, 0, 0, 0, 0, 3));
    add(0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 2));

    foreach (vecs[i]) begin
      cyc(vecs[i].r, vecs[i].kv, vecs[i].kd, vecs[i].ke, vecs[i].sm, vecs[i].lc);
      chk($sformatf("vec%0d", i), 32'(dut_out()), 32'(vecs[i].exp));
    end

    // short and over-long entries
    cyc(1, 0, 0, 0, 0, 0);
    key(1); key(2); enter(); idle(1);
    chk("short_tries", 32'(tries_left), 2);
    chk("short_locked", 32'(unlocked), 0);
    key(1); key(2); key(3); key(4); key(9); enter(); idle(5);
    chk("overlong_open", 32'(unlocked), 1);
    chk("open_tries", 32'(tries_left), 3);
    cyc(0, 0, 0, 0, 0, 1);
    chk("lock_cmd", 32'(unlocked), 0);

    // code change
    code_entry(16'h1234); idle(5);
    cyc(0, 0, 0, 0, 1, 0);
    chk("set_entry_unl", 32'(unlocked), 1);
    key(7); key(7); key(0); key(1); enter();
    chk("set_stay_open", 32'(unlocked), 1);
    cyc(0, 0, 0, 0, 0, 1);
    code_entry(16'h1234); idle(5);
    chk("old_code_fail", 32'(unlocked), 0);
    chk("old_code_tries", 32'(tries_left), 2);
    code_entry(16'h7701); idle(5);
    chk("new_code_open", 32'(unlocked), 1);
    cyc(0, 0, 0, 0, 1, 0);
    key(7); enter();
    chk("set_short_cerr", 32'(code_err), 1);
    idle(1);
    chk("cerr_pulse", 32'(code_err), 0);
    cyc(0, 0, 0, 0, 0, 1);
    code_entry(16'h7701); idle(5);
    chk("code_kept", 32'(unlocked), 1);
    cyc(0, 0, 0, 0, 0, 1);

    // simultaneous strobes and aborted code change
    key(7); key(7); key(0);
    cyc(0, 1, 4'd1, 1, 0, 0); idle(1);
    chk("kv_ke_short", 32'(tries_left), 2);
    chk("kv_ke_locked", 32'(unlocked), 0);
    code_entry(16'h7701); idle(5);
    cyc(0, 0, 0, 0, 1, 1);
    chk("lc_over_sm", 32'(unlocked), 0);
    idle(2);
    chk("stays_locked", 32'(unlocked), 0);
    code_entry(16'h7701); idle(5);
    cyc(0, 0, 0, 0, 1, 0); key(1); key(1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("abort_set", 32'(unlocked), 0);
    code_entry(16'h7701); idle(5);
    chk("abort_code_kept", 32'(unlocked), 1);
    cyc(0, 0, 0, 0, 0, 1);

    // reset mid-CHECK
    code_entry(16'h7701); idle(2);
    chk("busy_mid", 32'(busy), 1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tries", 32'(tries_left), 3);
    chk("rst_unl", 32'(unlocked), 0);
    code_entry(16'h1234); idle(5);
    chk("rst_code", 32'(unlocked), 1);
    cyc(0, 0, 0, 0, 0, 1);

    // reset mid-LOCKOUT
    for (int i = 0; i < 3; i++) begin
      code_entry(16'h1235); idle(5);
    end
    chk("lockout_on", 32'(lockout), 1);
    chk("lockout_tries", 32'(tries_left), 0);
    idle(3);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_lockout", 32'(lockout), 0);
    chk("rst_lo_tries", 32'(tries_left), 3);
    chk("rst_alarm", 32'(alarm), 0);

    // randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 30) begin
        code_entry(m_code);
      end else if (r < 45) begin
        n = $urandom_range(0, 6);
        for (int k = 0; k < n; k++) key(4'($urandom_range(0, 15)));
        enter();
      end else if (r < 52) begin
        cyc(0, 1, 4'($urandom_range(0, 15)), 1, 0, 0);
      end else if (r < 62) begin
        cyc(0, 0, 0, 0, 1, 0);
      end else if (r < 70) begin
        cyc(0, 0, 0, 0, 0, 1);
      end else if (r < 72) begin
        cyc(1, 0, 0, 0, 0, 0);
      end else if (r < 80) begin
        cyc(0, 0, 0, 0, 1, 1);
      end else begin
        idle($urandom_range(1, 12));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
